// File: rtl/led_spi_out.sv
`default_nettype none
// ============================================================================
// Module      : led_spi_out
// Description : Drains one LED colour RAM (ram_512_8 read port) and shifts it
//               out as an APA102-style clock+data frame: 4 x 0x00 start
//               bytes, per LED a {3'b111, brightness} header followed by
//               three colour bytes, then END_BYTES x 0xFF end bytes.
//               Optional macro LED_SPI_OUT_BGR_SWAP_EN emits the three colour
//               bytes of each LED in descending address order.
// Revision    : 1.0 - initial release
// ============================================================================
module led_spi_out #(
    parameter int NUM_LEDS  = 144,
    parameter int END_BYTES = 9,
    parameter int CLK_DIV   = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        send,
    input  logic [15:0] settings,
    output logic [8:0]  raddr,
    input  logic [7:0]  rdata,
    output logic        sck,
    output logic        sdo,
    output logic        busy,
    output logic        done
);

    localparam int c_DIV_W = $clog2(2 * CLK_DIV);
    localparam int c_BC_W  = $clog2(END_BYTES + 4);
    localparam int c_LED_W = $clog2(NUM_LEDS + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_HI   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [c_BC_W-1:0]  c_END_LAST = c_BC_W'(END_BYTES - 1);
    localparam logic [c_LED_W-1:0] c_LED_LAST = c_LED_W'(NUM_LEDS - 1);

`ifdef LED_SPI_OUT_BGR_SWAP_EN
    localparam logic [8:0] c_FIRST_ADDR = 9'd2;
`else
    localparam logic [8:0] c_FIRST_ADDR = 9'd0;
`endif

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_START   = 3'd1;
    localparam logic [2:0] c_LED_HDR = 3'd2;
    localparam logic [2:0] c_LED_COL = 3'd3;
    localparam logic [2:0] c_END     = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_bit;
    logic [c_BC_W-1:0]  r_byte_cnt;
    logic [c_LED_W-1:0] r_led;
    logic [7:0]         r_shreg;
    logic [8:0]         r_raddr;
    logic [4:0]         r_brt;
    logic               r_busy;
    logic               r_done;
    logic               r_sck;
    logic               r_pending;

    logic               w_go;
    logic               w_bit_end;
    logic               w_byte_end;
    logic               w_last_led;
    logic [7:0]         w_hdr;
    logic [7:0]         w_next_byte;
    logic               w_take_ram;
    logic [8:0]         w_next_raddr;
    logic               w_frame_end;
    logic               w_unused_settings;

    assign w_go       = (r_state == c_IDLE) && (send || r_pending);
    assign w_bit_end  = r_busy && (r_div == c_DIV_LAST);
    assign w_byte_end = w_bit_end && (r_bit == 3'd7);
    assign w_last_led = (r_led == c_LED_LAST);
    assign w_hdr      = {3'b111, r_brt};

    assign w_unused_settings = ^settings[15:5];

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: states advance only on byte boundaries
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (w_go) w_next_state = c_START;
            c_START:   if (w_byte_end && r_byte_cnt == c_BC_W'(3)) w_next_state = c_LED_HDR;
            c_LED_HDR: if (w_byte_end) w_next_state = c_LED_COL;
            c_LED_COL: if (w_byte_end && r_byte_cnt == c_BC_W'(2))
                           w_next_state = w_last_led ? c_END : c_LED_HDR;
            c_END:     if (w_byte_end && r_byte_cnt == c_END_LAST) w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    // Output logic: which byte is loaded at the coming boundary and the
    // address of the colour byte after the one being consumed from rdata
    always_comb begin
        w_next_byte  = 8'h00;
        w_take_ram   = 1'b0;
        w_frame_end  = 1'b0;
        w_next_raddr = r_raddr;
        case (r_state)
            c_START: begin
                w_next_byte = (r_byte_cnt == c_BC_W'(3)) ? w_hdr : 8'h00;
            end
            c_LED_HDR: begin
                w_next_byte = rdata;
                w_take_ram  = w_byte_end;
            end
            c_LED_COL: begin
                if (r_byte_cnt == c_BC_W'(2)) begin
                    w_next_byte = w_last_led ? 8'hFF : w_hdr;
                end else begin
                    w_next_byte = rdata;
                    w_take_ram  = w_byte_end;
                end
            end
            c_END: begin
                if (r_byte_cnt == c_END_LAST) begin
                    w_frame_end = w_byte_end;
                end else begin
                    w_next_byte = 8'hFF;
                end
            end
            default: w_next_byte = 8'h00;
        endcase
        // Colour byte k of the LED is loaded from HDR (k=0) or COL cnt 0/1 (k=1/2)
        if (r_state == c_LED_COL && r_byte_cnt == c_BC_W'(1)) begin
            // k=2 just consumed: move to the first byte of the next LED
            if (w_last_led) begin
                w_next_raddr = 9'd0;
            end else begin
`ifdef LED_SPI_OUT_BGR_SWAP_EN
                w_next_raddr = r_raddr + 9'd5;
`else
                w_next_raddr = r_raddr + 9'd1;
`endif
            end
        end else begin
`ifdef LED_SPI_OUT_BGR_SWAP_EN
            w_next_raddr = r_raddr - 9'd1;
`else
            w_next_raddr = r_raddr + 9'd1;
`endif
        end
    end

    // Bit timing, shift register, counters and RAM address prefetch
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_div      <= '0;
            r_bit      <= 3'd0;
            r_byte_cnt <= '0;
            r_led      <= '0;
            r_shreg    <= 8'h00;
            r_raddr    <= 9'd0;
            r_brt      <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sck      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_go) begin
                r_busy     <= 1'b1;
                r_brt      <= settings[4:0];
                r_shreg    <= 8'h00;
                r_div      <= '0;
                r_bit      <= 3'd0;
                r_byte_cnt <= '0;
                r_led      <= '0;
                r_raddr    <= c_FIRST_ADDR;
                r_sck      <= 1'b0;
            end else if (r_busy) begin
                if (w_bit_end) begin
                    r_div <= '0;
                    r_sck <= 1'b0;
                    r_bit <= r_bit + 3'd1;
                    if (w_byte_end) begin
                        r_shreg    <= w_next_byte;
                        r_byte_cnt <= (w_next_state != r_state) ? '0 : r_byte_cnt + 1'b1;
                        if (r_state == c_LED_COL && r_byte_cnt == c_BC_W'(2)) begin
                            r_led <= r_led + 1'b1;
                        end
                        if (w_take_ram) begin
                            r_raddr <= w_next_raddr;
                        end
                        if (w_frame_end) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end
                    end else begin
                        r_shreg <= {r_shreg[6:0], 1'b0};
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                    if (r_div == c_DIV_HI) begin
                        r_sck <= 1'b1;
                    end
                end
            end
        end
    end

    // Requests arriving mid-frame collapse into one pending start
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_go) begin
            r_pending <= 1'b0;
        end else if (r_busy && send) begin
            r_pending <= 1'b1;
        end
    end

    assign raddr = r_raddr;
    assign sck   = r_sck;
    assign sdo   = r_shreg[7];
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_spi_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_spi_out
// Description : Directed bench for led_spi_out: a CLK_DIV=1 instance for frame
//               content, brightness latch, reset abort and back-to-back
//               requests, and a CLK_DIV=3 instance for sck/sdo timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_spi_out;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: CLK_DIV = 1
    logic        send_a = 1'b0;
    logic [15:0] settings_a = 16'h0;
    logic [8:0]  raddr_a;
    logic [7:0]  rdata_a = 8'h00;
    logic        sck_a, sdo_a, busy_a, done_a;

    // Instance B: CLK_DIV = 3
    logic        send_b = 1'b0;
    logic [15:0] settings_b = 16'h0;
    logic [8:0]  raddr_b;
    logic [7:0]  rdata_b = 8'h00;
    logic        sck_b, sdo_b, busy_b, done_b;

    led_spi_out #(.NUM_LEDS(2), .END_BYTES(1), .CLK_DIV(1)) dut_a (
        .clk_sys(clk), .reset(reset), .send(send_a), .settings(settings_a),
        .raddr(raddr_a), .rdata(rdata_a), .sck(sck_a), .sdo(sdo_a),
        .busy(busy_a), .done(done_a)
    );

    led_spi_out #(.NUM_LEDS(2), .END_BYTES(1), .CLK_DIV(3)) dut_b (
        .clk_sys(clk), .reset(reset), .send(send_b), .settings(settings_b),
        .raddr(raddr_b), .rdata(rdata_b), .sck(sck_b), .sdo(sdo_b),
        .busy(busy_b), .done(done_b)
    );

    // Synchronous-read RAM model shared by both instances
    logic [7:0] mem [0:511];
    always @(posedge clk) begin
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- byte capture on sck rise ----------------
    logic [7:0] acc_a, acc_b;
    int         nbits_a, nbits_b;
    logic [7:0] bytes_a [$];
    logic [7:0] bytes_b [$];

    always @(posedge sck_a or posedge reset) begin
        if (reset) nbits_a = 0;
        else begin
            acc_a = {acc_a[6:0], sdo_a};
            nbits_a++;
            if (nbits_a == 8) begin bytes_a.push_back(acc_a); nbits_a = 0; end
        end
    end

    always @(posedge sck_b or posedge reset) begin
        if (reset) nbits_b = 0;
        else begin
            acc_b = {acc_b[6:0], sdo_b};
            nbits_b++;
            if (nbits_b == 8) begin bytes_b.push_back(acc_b); nbits_b = 0; end
        end
    end

    // ---------------- per-cycle monitors (negedge) ----------------
    int busy_cnt_a, done_cnt_a, done_bad_a, rises_a, rises_after_done_a, raddr_over_a;
    logic prev_busy_a = 1'b0, prev_done_a = 1'b0;
    logic [8:0] last_raddr_a = 9'd0;
    logic [8:0] rlog_a [$];

    always @(negedge clk) begin
        if (busy_a) busy_cnt_a++;
        if (done_a) begin
            done_cnt_a++;
            if (busy_a || sdo_a || sck_a) done_bad_a++;
        end
        if (busy_a && !prev_busy_a) begin
            rises_a++;
            if (prev_done_a) rises_after_done_a++;
        end
        if (busy_a && (!prev_busy_a || raddr_a != last_raddr_a)) rlog_a.push_back(raddr_a);
        if (raddr_a > 9'd5) raddr_over_a++;
        last_raddr_a = raddr_a;
        prev_busy_a  = busy_a;
        prev_done_a  = done_a;
    end

    int busy_cnt_b, done_cnt_b, run_b, runbad_b, sdobad_b;
    logic prev_busy_b = 1'b0, prev_sck_b = 1'b0, prev_sdo_b = 1'b0;

    always @(negedge clk) begin
        if (busy_b) busy_cnt_b++;
        if (done_b) done_cnt_b++;
        if (busy_b) begin
            if (!prev_busy_b) run_b = 1;
            else if (sck_b == prev_sck_b) run_b++;
            else begin
                if (run_b != 3) runbad_b++;
                run_b = 1;
            end
            if (prev_busy_b && sdo_b != prev_sdo_b && !(prev_sck_b && !sck_b)) sdobad_b++;
        end else if (prev_busy_b) begin
            if (run_b != 3) runbad_b++;
        end
        prev_busy_b = busy_b;
        prev_sck_b  = sck_b;
        prev_sdo_b  = sdo_b;
    end

    // ---------------- expected frame model ----------------
    logic [7:0] cols_exp [0:5];
    logic [7:0] exp_bytes [0:12];

    task automatic build_exp(input logic [4:0] b);
        for (int i = 0; i < 4; i++) exp_bytes[i] = 8'h00;
        exp_bytes[4] = {3'b111, b};
        for (int i = 0; i < 3; i++) exp_bytes[5 + i] = cols_exp[i];
        exp_bytes[8] = {3'b111, b};
        for (int i = 0; i < 3; i++) exp_bytes[9 + i] = cols_exp[3 + i];
        exp_bytes[12] = 8'hFF;
    endtask

    task automatic compare_frame(input string tag, input logic [7:0] q[$], input int offset);
        int act;
        for (int i = 0; i < 13; i++) begin
            act = (q.size() > offset + i) ? int'(q[offset + i]) : -1;
            check($sformatf("%s byte%0d", tag, i), act, int'(exp_bytes[i]));
        end
    endtask

    task automatic clear_a();
        bytes_a.delete();
        rlog_a.delete();
        busy_cnt_a = 0; done_cnt_a = 0; done_bad_a = 0;
        rises_a = 0; rises_after_done_a = 0;
    endtask

    // One frame on instance A; settings change to b1 'mid' cycles after send
    task automatic run_a(input logic [4:0] b0, input logic [4:0] b1, input int mid);
        clear_a();
        @(negedge clk);
        settings_a = {11'h0, b0};
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        for (int i = 0; i < 600 && done_cnt_a == 0; i++) begin
            if (i == mid) settings_a = {11'h0, b1};
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        logic [4:0] brt_send;
        logic [4:0] brt_mid;
        int         mid;
    } frame_vec_t;

    frame_vec_t vecs [0:3];

    initial begin
        vecs[0] = '{brt_send: 5'h1F, brt_mid: 5'h1F, mid: 10};
        vecs[1] = '{brt_send: 5'h03, brt_mid: 5'h1F, mid: 30};
        vecs[2] = '{brt_send: 5'h0A, brt_mid: 5'h00, mid: 100};
        vecs[3] = '{brt_send: 5'h15, brt_mid: 5'h03, mid: 150};

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
`ifdef LED_SPI_OUT_BGR_SWAP_EN
        cols_exp[0] = 8'h33; cols_exp[1] = 8'h22; cols_exp[2] = 8'h11;
        cols_exp[3] = 8'h66; cols_exp[4] = 8'h55; cols_exp[5] = 8'h44;
`else
        cols_exp[0] = 8'h11; cols_exp[1] = 8'h22; cols_exp[2] = 8'h33;
        cols_exp[3] = 8'h44; cols_exp[4] = 8'h55; cols_exp[5] = 8'h66;
`endif
        raddr_over_a = 0;
        busy_cnt_b = 0; done_cnt_b = 0; run_b = 0; runbad_b = 0; sdobad_b = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset sck", int'(sck_a), 0);
        check("reset sdo", int'(sdo_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset done", int'(done_a), 0);
        check("reset raddr", int'(raddr_a), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table of single frames with brightness latch checks
        for (int v = 0; v < 4; v++) begin
            run_a(vecs[v].brt_send, vecs[v].brt_mid, vecs[v].mid);
            build_exp(vecs[v].brt_send);
            compare_frame($sformatf("frame%0d", v), bytes_a, 0);
            check($sformatf("frame%0d nbytes", v), bytes_a.size(), 13);
            check($sformatf("frame%0d busy cycles", v), busy_cnt_a, 208);
            check($sformatf("frame%0d done pulses", v), done_cnt_a, 1);
            check($sformatf("frame%0d done-cycle outputs", v), done_bad_a, 0);
            if (v == 0) begin
                check("raddr log len", rlog_a.size(), 7);
                for (int k = 0; k < 7; k++) begin
`ifdef LED_SPI_OUT_BGR_SWAP_EN
                    check($sformatf("raddr seq%0d", k), (rlog_a.size() > k) ? int'(rlog_a[k]) : -1,
                          (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 0 : (k == 3) ? 5 :
                          (k == 4) ? 4 : (k == 5) ? 3 : 0);
`else
                    check($sformatf("raddr seq%0d", k), (rlog_a.size() > k) ? int'(rlog_a[k]) : -1,
                          (k < 6) ? k : 0);
`endif
                end
            end
        end

        // Reset mid-frame aborts immediately, then a full frame follows
        clear_a();
        @(negedge clk);
        settings_a = 16'h001F;
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        repeat (60) @(negedge clk);
        check("pre-reset busy", int'(busy_a), 1);
        reset = 1'b1;
        #1;
        check("abort sck", int'(sck_a), 0);
        check("abort sdo", int'(sdo_a), 0);
        check("abort busy", int'(busy_a), 0);
        check("abort done", int'(done_a), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort no done", done_cnt_a, 0);
        run_a(5'h1F, 5'h1F, 0);
        build_exp(5'h1F);
        compare_frame("post-reset", bytes_a, 0);
        check("post-reset busy cycles", busy_cnt_a, 208);
        check("post-reset done pulses", done_cnt_a, 1);

        // Back-to-back: extra sends at 20 and 40 cycles collapse into one frame
        clear_a();
        @(negedge clk);
        settings_a = 16'h0007;
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        repeat (19) @(negedge clk);
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        repeat (19) @(negedge clk);
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        for (int i = 0; i < 1000 && done_cnt_a < 2; i++) @(negedge clk);
        repeat (300) @(negedge clk);
        build_exp(5'h07);
        check("b2b done pulses", done_cnt_a, 2);
        check("b2b busy rises", rises_a, 2);
        check("b2b rise after done", rises_after_done_a, 1);
        check("b2b busy cycles", busy_cnt_a, 416);
        check("b2b nbytes", bytes_a.size(), 26);
        compare_frame("b2b f1", bytes_a, 0);
        compare_frame("b2b f2", bytes_a, 13);

        // CLK_DIV=3 timing on instance B
        @(negedge clk);
        settings_b = 16'h001F;
        send_b = 1'b1;
        @(negedge clk);
        send_b = 1'b0;
        for (int i = 0; i < 2000 && done_cnt_b == 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        build_exp(5'h1F);
        compare_frame("div3", bytes_b, 0);
        check("div3 busy cycles", busy_cnt_b, 624);
        check("div3 done pulses", done_cnt_b, 1);
        check("div3 phase lengths", runbad_b, 0);
        check("div3 sdo stability", sdobad_b, 0);

        check("raddr range", raddr_over_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
